lgn_frame_ctrl: RTL and testbench

Parametrised frame controller for the logic-gate-network (LGN) classifier. It assembles a binary image from narrow pad-level write words, holds the image steady on the network inputs, and waits a fixed network latency. It then scans the network's class-group outputs one class per cycle, computing a popcount for each, and presents the winning class index and its score on the output pads. It replaces the direct pin-to-network wiring in the chip core.

---
 rtl/lgn_frame_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_lgn_frame_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lgn_frame_ctrl.sv
// LGN frame controller: assembles an image from pad words, waits for the network, then scans
// class groups for the highest popcount. Define LGN_IN_SYNC_EN to synchronise the pad strobe.
module lgn_frame_ctrl #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned IMG_BITS  = 400,
  parameter int unsigned CLASSES   = 10,
  parameter int unsigned GROUP_W   = 100,
  parameter int unsigned NET_LAT   = 2,
  localparam int unsigned WORDS    = (IMG_BITS + IN_W - 1) / IN_W,
  localparam int unsigned IDX_W    = $clog2(CLASSES),
  localparam int unsigned SC_W     = $clog2(GROUP_W + 1),
  localparam int unsigned CNT_W    = $clog2(WORDS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IN_W-1:0]            wr_data,
  output logic [IMG_BITS-1:0]        img,
  input  logic [CLASSES*GROUP_W-1:0] net_out,
  output logic                       busy,
  output logic                       valid,
  output logic [IDX_W-1:0]           class_idx,
  output logic [SC_W-1:0]            score,
  output logic [CNT_W-1:0]           word_cnt
);

  localparam int unsigned LAT_W = $clog2(NET_LAT + 1);

  typedef enum logic [1:0] {StLoad, StWait, StScan, StDone} state_e;

  state_e              state_q, state_d;
  logic [IMG_BITS-1:0] img_q, img_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [IDX_W-1:0]    cls_q, cls_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [SC_W-1:0]     best_sc_q, best_sc_d;
  logic [IDX_W-1:0]    class_idx_q, class_idx_d;
  logic [SC_W-1:0]     score_q, score_d;
  logic                valid_q, valid_d;

  logic                acc;
  logic [IN_W-1:0]     acc_data;
  logic                wr_go;
  logic [CNT_W-1:0]    wr_idx;
  logic [GROUP_W-1:0]  grp;
  logic [SC_W-1:0]     pc;

`ifdef LGN_IN_SYNC_EN
  logic            en_s1_q, en_s2_q, en_s3_q;
  logic [IN_W-1:0] dat_s1_q, dat_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_s1_q  <= 1'b0;
      en_s2_q  <= 1'b0;
      en_s3_q  <= 1'b0;
      dat_s1_q <= '0;
      dat_s2_q <= '0;
    end else begin
      en_s1_q  <= wr_en;
      en_s2_q  <= en_s1_q;
      en_s3_q  <= en_s2_q;
      dat_s1_q <= wr_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // One word per pad pulse: accept only on the synchronised rising edge.
  assign acc      = en_s2_q & ~en_s3_q;
  assign acc_data = dat_s2_q;
`else
  assign acc      = wr_en;
  assign acc_data = wr_data;
`endif

  always_comb begin
    grp = net_out[int'(cls_q) * int'(GROUP_W) +: GROUP_W];
    pc  = '0;
    for (int i = 0; i < int'(GROUP_W); i++) begin
      pc = pc + SC_W'(grp[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    img_d       = img_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    cls_d       = cls_q;
    best_idx_d  = best_idx_q;
    best_sc_d   = best_sc_q;
    class_idx_d = class_idx_q;
    score_d     = score_q;
    valid_d     = valid_q;
    wr_go       = 1'b0;
    wr_idx      = cnt_q;

    unique case (state_q)
      StLoad: begin
        if (acc) begin
          wr_go = 1'b1;
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            cnt_d   = '0;
            lat_d   = '0;
            state_d = StWait;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StWait: begin
        if (lat_q == LAT_W'(NET_LAT - 1)) begin
          cls_d   = '0;
          state_d = StScan;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      StScan: begin
        // Strict compare keeps the lowest index on ties.
        if (cls_q == '0 || pc > best_sc_q) begin
          best_idx_d = cls_q;
          best_sc_d  = pc;
        end
        if (cls_q == IDX_W'(CLASSES - 1)) begin
          class_idx_d = best_idx_d;
          score_d     = best_sc_d;
          valid_d     = 1'b1;
          state_d     = StDone;
        end else begin
          cls_d = cls_q + IDX_W'(1);
        end
      end
      StDone: begin
        if (acc) begin
          wr_go   = 1'b1;
          wr_idx  = '0;
          cnt_d   = CNT_W'(1);
          valid_d = 1'b0;
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase

    // Bits of the final word that fall beyond IMG_BITS are simply never written.
    if (wr_go) begin
      for (int i = 0; i < int'(IMG_BITS); i++) begin
        if (i / int'(IN_W) == int'(wr_idx)) img_d[i] = acc_data[i % int'(IN_W)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      img_q       <= '0;
      cnt_q       <= '0;
      lat_q       <= '0;
      cls_q       <= '0;
      best_idx_q  <= '0;
      best_sc_q   <= '0;
      class_idx_q <= '0;
      score_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      img_q       <= img_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      cls_q       <= cls_d;
      best_idx_q  <= best_idx_d;
      best_sc_q   <= best_sc_d;
      class_idx_q <= class_idx_d;
      score_q     <= score_d;
      valid_q     <= valid_d;
    end
  end

  assign img       = img_q;
  assign busy      = (state_q == StWait) || (state_q == StScan);
  assign valid     = valid_q;
  assign class_idx = class_idx_q;
  assign score     = score_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_lgn_frame_ctrl.sv
// Randomised bench for lgn_frame_ctrl against a frame-level model of image assembly and
// winner selection; also exercises the LGN_IN_SYNC_EN build when that macro is defined.
module tb_lgn_frame_ctrl;

  localparam int unsigned IN_W     = 8;
  localparam int unsigned IMG_BITS = 400;
  localparam int unsigned CLASSES  = 10;
  localparam int unsigned GROUP_W  = 100;
  localparam int unsigned NET_LAT  = 2;
  localparam int unsigned WORDS    = 50;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned SC_W     = 7;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned LATENCY  = NET_LAT + CLASSES;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       wr_en;
  logic [IN_W-1:0]            wr_data;
  logic [IMG_BITS-1:0]        img;
  logic [CLASSES*GROUP_W-1:0] net_out;
  logic                       busy;
  logic                       valid;
  logic [IDX_W-1:0]           class_idx;
  logic [SC_W-1:0]            score;
  logic [CNT_W-1:0]           word_cnt;

  lgn_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .img       (img),
    .net_out   (net_out),
    .busy      (busy),
    .valid     (valid),
    .class_idx (class_idx),
    .score     (score),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IMG_BITS-1:0] img_model;

  task automatic check_eq(input string tag, input logic [IMG_BITS-1:0] got,
                          input logic [IMG_BITS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void put_word(input int k, input logic [IN_W-1:0] d);
    for (int b = 0; b < int'(IN_W); b++) begin
      if (k * int'(IN_W) + b < int'(IMG_BITS)) img_model[k * int'(IN_W) + b] = d[b];
    end
  endfunction

  // Winner = highest popcount, earliest class on ties.
  task automatic predict(output int idx, output int sc);
    int pc;
    idx = 0;
    sc  = -1;
    for (int c = 0; c < int'(CLASSES); c++) begin
      pc = $countones(net_out[c * int'(GROUP_W) +: GROUP_W]);
      if (pc > sc) begin
        sc  = pc;
        idx = c;
      end
    end
  endtask

  task automatic set_group(input int c, input int n);
    int placed;
    int p;
    placed = 0;
    for (int b = 0; b < int'(GROUP_W); b++) net_out[c * int'(GROUP_W) + b] = 1'b0;
    while (placed < n) begin
      p = int'($urandom_range(GROUP_W - 1, 0));
      if (!net_out[c * int'(GROUP_W) + p]) begin
        net_out[c * int'(GROUP_W) + p] = 1'b1;
        placed++;
      end
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send_word(input int k, input logic [IN_W-1:0] d);
    put_word(k, d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
`ifdef LGN_IN_SYNC_EN
    wr_en = 1'b0;
    @(negedge clk);
`endif
  endtask

  task automatic send_words(input int first, input int last, input bit gaps);
    for (int k = first; k <= last; k++) begin
      if (gaps && $urandom_range(3, 0) == 0) begin
        wr_en = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      send_word(k, IN_W'($urandom));
    end
  endtask

  task automatic wait_result();
    int idx;
    int sc;
    int n;
    predict(idx, sc);
    wr_en = 1'b0;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    check_eq("busy_start", busy, 1);
    check_eq("img_frozen", img, img_model);
    check_eq("cnt_in_wait", word_cnt, 0);
    n = 0;
    while (busy && n < 4 * int'(LATENCY)) begin
      n++;
      @(negedge clk);
    end
    check_eq("busy_cycles", n, LATENCY);
    check_eq("valid", valid, 1);
    check_eq("class_idx", class_idx, idx);
    check_eq("score", score, sc);
    check_eq("img_result", img, img_model);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    img_model = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int sc;
    int n;
    int first;
    int a;
    int b;
    int top;
    logic [IN_W-1:0] d;

    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    net_out   = '0;
    img_model = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_img", img, 0);
    check_eq("rst_cnt", word_cnt, 0);
    check_eq("rst_idx", class_idx, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", valid, 0);

`ifdef LGN_IN_SYNC_EN
    // A 5-cycle pad pulse yields exactly one word, accepted at the 3rd edge.
    wr_data = 8'hA5;
    wr_en   = 1'b1;
    put_word(0, 8'hA5);
    first = 0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 5) wr_en = 1'b0;
      if (word_cnt != 0 && first == 0) first = e;
    end
    check_eq("sync_accept_edge", first, 3);
    check_eq("sync_one_word", word_cnt, 1);
    check_eq("sync_img", img, img_model);
    do_reset();
`endif

    // All-ones image, class 3 saturated.
    net_out = '0;
    net_out[3 * GROUP_W +: GROUP_W] = '1;
    for (int k = 0; k < int'(WORDS); k++) send_word(k, 8'hFF);
    wait_result();
    check_eq("ones_idx", class_idx, 3);
    check_eq("ones_score", score, 100);
    check_eq("ones_img", img, {IMG_BITS{1'b1}});

    // Tie between classes 2 and 7.
    for (int c = 0; c < int'(CLASSES); c++) set_group(c, (c == 2 || c == 7) ? 60 : 10);
    send_words(0, WORDS - 1, 1'b0);
    wait_result();
    check_eq("tie_idx", class_idx, 2);
    check_eq("tie_score", score, 60);

`ifndef LGN_IN_SYNC_EN
    // Strobe held high through WAIT/SCAN; only the first DONE-cycle word is taken.
    for (int c = 0; c < int'(CLASSES); c++) set_group(c, int'($urandom_range(GROUP_W, 0)));
    predict(idx, sc);
    send_words(0, WORDS - 1, 1'b0);
    n = 0;
    while (busy && n < 4 * int'(LATENCY)) begin
      check_eq("hold_img", img, img_model);
      check_eq("hold_cnt", word_cnt, 0);
      wr_data = IN_W'($urandom);
      n++;
      @(negedge clk);
    end
    check_eq("hold_busy_cycles", n, LATENCY);
    check_eq("hold_valid", valid, 1);
    check_eq("hold_idx", class_idx, idx);
    d = IN_W'($urandom);
    send_word(0, d);
    check_eq("done_write_cnt", word_cnt, 1);
    check_eq("done_write_valid", valid, 0);
    check_eq("done_write_img", img, img_model);
    send_words(1, WORDS - 1, 1'b1);
    wait_result();
`endif

    // Reset after 20 words discards the partial frame.
    for (int c = 0; c < int'(CLASSES); c++) set_group(c, int'($urandom_range(GROUP_W, 0)));
    send_words(0, 19, 1'b0);
    rst   = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    img_model = '0;
    check_eq("midrst_cnt", word_cnt, 0);
    check_eq("midrst_img", img, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_valid", valid, 0);
    send_words(0, WORDS - 1, 1'b1);
    wait_result();

    // Back-to-back: A wins class 5, B starts the cycle after valid and wins class 0.
    for (int c = 0; c < int'(CLASSES); c++) set_group(c, int'($urandom_range(50, 0)));
    set_group(5, 90);
    send_words(0, WORDS - 1, 1'b0);
    wait_result();
    check_eq("b2b_a_idx", class_idx, 5);
    for (int c = 0; c < int'(CLASSES); c++) set_group(c, int'($urandom_range(50, 0)));
    set_group(0, 95);
    send_word(0, IN_W'($urandom));
    for (int i = 0; i < 6 && word_cnt == 0; i++) @(negedge clk);
    check_eq("b2b_valid_drop", valid, 0);
    check_eq("b2b_cnt", word_cnt, 1);
    send_words(1, WORDS - 1, 1'b0);
    wait_result();
    check_eq("b2b_b_idx", class_idx, 0);

    // Random frames, some with a forced tie at the maximum.
    repeat (6) begin
      top = int'($urandom_range(GROUP_W, 1));
      for (int c = 0; c < int'(CLASSES); c++) set_group(c, int'($urandom_range(top - 1, 0)));
      a = int'($urandom_range(CLASSES - 1, 0));
      b = int'($urandom_range(CLASSES - 1, 0));
      set_group(a, top);
      if ($urandom_range(1, 0) == 1) set_group(b, top);
      send_words(0, WORDS - 1, 1'b1);
      wait_result();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
